// File: rtl/gpu_pkg.sv
// Shared types for the frame sequencer: signed fixed-point matrix elements,
// 4x4 matrix container, sequencer states and the identity-matrix constant.
package gpu_pkg;

    localparam int M    = 11;
    localparam int N    = 7;
    localparam int FX_W = M + N;

    typedef logic signed [FX_W-1:0] fx_t;
    typedef fx_t [0:15] mat4_t;

    localparam fx_t FX_ONE = fx_t'(1 << N);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VSYNC,
        START,
        RUN
    } state_t;

    // Row-major 4x4, so the diagonal sits on indices 0, 5, 10, 15.
    function automatic mat4_t identity_mat();
        mat4_t m;
        for (int i = 0; i < 16; i++) begin
            m[i] = (i % 5 == 0) ? FX_ONE : '0;
        end
        return m;
    endfunction

endpackage

// File: rtl/matrix_bank.sv
// Double-buffered transform matrix: writes land in staging, commit copies
// staging to the active bank seen by the GPU. Both banks reset to identity.
module matrix_bank
    import gpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  fx_t         wr_data,
    input  logic        commit,
    output mat4_t       active
);

    mat4_t staging;

    // Commit reads staging's pre-edge value, so a same-cycle write only
    // reaches active on the following commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            staging <= identity_mat();
            active  <= identity_mat();
        end else begin
            if (wr_en) begin
                staging[wr_idx] <= wr_data;
            end
            if (commit) begin
                active <= staging;
            end
        end
    end

endmodule

// File: rtl/gpu_frame_sequencer.sv
// Per-frame GPU controller: accepts one draw command, optionally waits for a
// vsync rising edge, pulses start, then waits for frame_end under a watchdog.
module gpu_frame_sequencer
    import gpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16777216,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [31:0]            cmd_vertex_count,
    input  logic                   cmd_wait_vsync,
    input  logic                   mat_wr_en,
    input  logic [3:0]             mat_wr_idx,
    input  fx_t                    mat_wr_data,
    input  logic                   vsync,
    output logic [31:0]            gpu_vertex_count,
    output logic                   gpu_start,
    output mat4_t                  gpu_transform_matrix,
    input  logic                   gpu_frame_end,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   timeout_err,
    output logic [FRAME_CNT_W-1:0] frame_counter
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t            state;
    state_t            next_state;
    logic              vsync_q;
    logic [WD_W-1:0]   watchdog;
    logic [31:0]       cnt;
    logic              accept;
    logic              zero_accept;
    logic              commit;
    logic              vsync_rise;
    logic              wd_expire;
    logic              run_end;

    always_comb begin
        accept      = cmd_valid & cmd_ready;
        cnt         = cmd_vertex_count & 32'hFFFF_FFFC;
        zero_accept = accept & (cnt == 32'd0);
        commit      = accept & (cnt != 32'd0);
        vsync_rise  = vsync & ~vsync_q;
        wd_expire   = (watchdog == WD_W'(TIMEOUT_CYCLES - 1));
        run_end     = (state == RUN) & gpu_frame_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (commit) next_state = cmd_wait_vsync ? WAIT_VSYNC : START;
            WAIT_VSYNC: if (vsync_rise) next_state = START;
            START:      next_state = RUN;
            RUN:        if (gpu_frame_end || wd_expire) next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q          <= 1'b0;
            cmd_ready        <= 1'b1;
            busy             <= 1'b0;
            gpu_start        <= 1'b0;
            frame_done       <= 1'b0;
            timeout_err      <= 1'b0;
            gpu_vertex_count <= 32'd0;
            frame_counter    <= '0;
            watchdog         <= '0;
        end else begin
            vsync_q     <= vsync;
            cmd_ready   <= (next_state == IDLE) & ~zero_accept;
            busy        <= (next_state != IDLE);
            gpu_start   <= (next_state == START);
            frame_done  <= zero_accept | run_end;
            timeout_err <= (state == RUN) & ~gpu_frame_end & wd_expire;
            if (commit) begin
                gpu_vertex_count <= cnt;
            end
            if (run_end) begin
                frame_counter <= frame_counter + FRAME_CNT_W'(1);
            end
            if (state == START) begin
                watchdog <= '0;
            end else if (state == RUN) begin
                watchdog <= watchdog + WD_W'(1);
            end
        end
    end

    matrix_bank u_matrix_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (mat_wr_en),
        .wr_idx  (mat_wr_idx),
        .wr_data (mat_wr_data),
        .commit  (commit),
        .active  (gpu_transform_matrix)
    );

endmodule

// File: doc/gpu_frame_sequencer.md
Name: gpu_frame_sequencer

Overview:
Per-frame controller in front of the GPU top level. Accepts one draw command at a time over a valid/ready handshake and double-buffers the 4x4 fixed-point transform matrix, so matrix updates never tear a frame in flight. Optionally aligns frame start to display vsync, issues the single-cycle start pulse, and waits for frame_end with a watchdog. It sits between the CPU/register interface and the GPU top level's vertex_count, start, transform_matrix and frame_end signals.

Parameters:
M, 11, integer bits of fixed-point matrix element
N, 7, fractional bits of fixed-point matrix element (element width FX_W = M+N = 18, signed)
TIMEOUT_CYCLES, 16777216, RUN-state watchdog limit in clk cycles
FRAME_CNT_W, 16, width of frame_counter

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
cmd_valid  in  1  draw command offered
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_vertex_count  in  32  vertices to draw
cmd_wait_vsync  in  1  1 = hold start until next vsync rising edge
mat_wr_en  in  1  write one staging-matrix element
mat_wr_idx  in  4  element index, row-major 0..15
mat_wr_data  in  FX_W  signed element value
vsync  in  1  display vsync, synchronous to clk
gpu_vertex_count  out  32  vertex count driven to GPU; stable from START through RUN
gpu_start  out  1  one-cycle start pulse to GPU
gpu_transform_matrix  out  16 x FX_W  active matrix bank, signed
gpu_frame_end  in  1  GPU frame-complete pulse
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse when a frame completes or a zero-count command is retired
timeout_err  out  1  one-cycle pulse on watchdog expiry
frame_counter  out  FRAME_CNT_W  completed frames; wraps to 0

Behaviour:
- Reset: state IDLE; cmd_ready=1; gpu_start, busy, frame_done, timeout_err = 0; gpu_vertex_count = 0; frame_counter = 0; watchdog = 0; vsync history = 0.
- Reset also loads both matrix banks with identity: 128 (1<<N) on indices 0, 5, 10, 15; 0 elsewhere. Reset mid-frame aborts immediately with no pulses emitted.
- Staging bank: mat_wr_en writes staging[mat_wr_idx] <= mat_wr_data on any cycle, in any state.
- Active bank changes only at command accept. It copies the staging contents from before that edge, so a write in the accept cycle lands in staging only.
- Accept = cmd_valid & cmd_ready at a rising edge. On accept, cnt = cmd_vertex_count & 32'hFFFF_FFFC.
- cnt == 0: no GPU start and no matrix copy; frame_done pulses the next cycle; frame_counter is unchanged; state stays IDLE, with cmd_ready low for that one cycle.
- cnt != 0: gpu_vertex_count <= cnt; commit staging to active; go to WAIT_VSYNC if cmd_wait_vsync, else START.
- WAIT_VSYNC: leave on vsync rising edge, detected as vsync & ~vsync_q with a 1-cycle registered history; go to START. A vsync high at entry with no rising edge does not qualify.
- START: gpu_start = 1 for exactly this cycle; watchdog cleared; next state RUN.
- Latency: accept at edge t without vsync wait gives gpu_start high during cycle t+1.
- RUN: watchdog increments each cycle.
  - On gpu_frame_end: frame_done pulses next cycle; frame_counter += 1 (wraps); next state IDLE.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without frame_end: timeout_err pulses; next state IDLE; frame_counter unchanged.
  - If frame_end and watchdog expiry coincide, frame_end wins.
- gpu_frame_end outside RUN is ignored. This includes the START cycle.
- All outputs are registered. gpu_transform_matrix is the active bank register, directly.

Decomposition:
- gpu_pkg holds:
  - M, N, FX_W, FX_ONE = 1<<N
  - typedef fx_t (logic signed [FX_W-1:0]) and mat4_t (fx_t [0:15])
  - state enum {IDLE, WAIT_VSYNC, START, RUN}
  - function identity_mat()
- One sub-module, matrix_bank: staging and active registers, write port, commit strobe, identity reset.
- The FSM, watchdog and counters stay in the top.

Test Plan:
- Count 10, no vsync wait: accept at t -> gpu_vertex_count=8, gpu_start high only in cycle t+1; frame_end 50 cycles later -> frame_done pulse next cycle, frame_counter=1, cmd_ready=1.
- Write idx 0 = -256 during RUN -> gpu_transform_matrix[0] stays 128; next accept -> [0] = -256. A write to idx 3 in the accept cycle is absent from active until the following command.
- cmd_wait_vsync=1, vsync held high at entry, low at +20, high at +40 -> gpu_start 1 cycle after the rising edge at +40, not before.
- Count 3 -> masked to 0: no gpu_start, frame_done pulses 1 cycle after accept, frame_counter unchanged.
- TIMEOUT_CYCLES=64, no frame_end -> timeout_err pulse, return to IDLE, frame_counter unchanged; a late frame_end in IDLE is ignored.
- Reset asserted in RUN, then frame_end -> all outputs at reset values, matrix back to identity, no frame_done pulse.
